// File: rtl/vr_alu_seq.sv
// Multi-cycle RV32I/RV64I ALU: single-cycle base ops, iterative shifter,
// radix-2 shift-add multiplier and restoring divider sharing one accumulator.
module vr_alu_seq #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter bit EN_M       = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_flush,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_in1,
  input  logic [XLEN-1:0] i_in2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_out,
  output logic            o_EQ,
  output logic            o_LT,
  output logic            o_LTU,
  output logic [XLEN-1:0] o_ALUadd
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d, out_q, out_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                sra_q, sra_d, neg_q, neg_d, rneg_q, rneg_d;

  // Flags and address adder look only at the live operands.
  logic [XLEN:0] diff;
  assign diff     = {1'b0, i_in1} - {1'b0, i_in2};
  assign o_ALUadd = i_in1 + i_in2;
  assign o_EQ     = (i_in1 == i_in2);
  assign o_LTU    = diff[XLEN];
  assign o_LT     = (i_in1[XLEN-1] != i_in2[XLEN-1]) ? i_in1[XLEN-1] : diff[XLEN];

  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            is_m, sgn1, sgn2, s1n, s2n;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] a_mag, b_mag, base_res;

  assign f3    = i_instr[14:12];
  assign f7    = i_instr[31:25];
  assign is_m  = EN_M && i_instr[5] && (f7 == 7'b0000001);
  assign sgn1  = is_m && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
  assign sgn2  = is_m && (f3 inside {3'd0, 3'd1, 3'd4, 3'd6});
  assign s1n   = sgn1 & i_in1[XLEN-1];
  assign s2n   = sgn2 & i_in2[XLEN-1];
  assign a_mag = s1n ? -i_in1 : i_in1;
  assign b_mag = s2n ? -i_in2 : i_in2;
  assign shamt = i_instr[5] ? i_in2[SW-1:0] : i_instr[20 +: SW];

  always_comb begin
    base_res = '0;
    case (f3)
      3'd0: base_res = (f7[5] & i_instr[5]) ? diff[XLEN-1:0] : o_ALUadd;
      3'd2: base_res = {{(XLEN-1){1'b0}}, o_LT};
      3'd3: base_res = {{(XLEN-1){1'b0}}, o_LTU};
      3'd4: base_res = i_in1 ^ i_in2;
      3'd6: base_res = i_in1 | i_in2;
      3'd7: base_res = i_in1 & i_in2;
      default: base_res = '0;
    endcase
  end

  // Shifter step: min(remaining, SHIFT_STEP) bits per cycle.
  logic [CW-1:0]   amt;
  logic [XLEN-1:0] sh_lo, sh_res;
  assign amt    = (cnt_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : cnt_q;
  assign sh_lo  = acc_q[XLEN-1:0];
  assign sh_res = (f3_q == 3'd1) ? (sh_lo << amt) :
                  sra_q ? XLEN'($signed(sh_lo) >>> amt) : (sh_lo >> amt);

  // acc = {high partial product, multiplier} or {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, r_sh, r_sub;
  logic              ge;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, fix_res;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign r_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign ge       = (r_sh >= {1'b0, opb_q});
  assign r_sub    = r_sh - {1'b0, opb_q};
  assign div_next = {(ge ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign q_fix    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign r_fix    = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_res  = !f3_q[2] ? ((f3_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN])
                             : (f3_q[1] ? r_fix : q_fix);

  assign o_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign o_busy  = (state_q == S_SHIFT) || (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign o_done  = (state_q == S_DONE);
  assign o_out   = out_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    sra_d   = sra_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    out_d   = out_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else if (i_valid && o_ready) begin
      f3_d   = f3;
      sra_d  = f7[5];
      neg_d  = s1n ^ s2n;
      rneg_d = s1n;
      if (is_m && !f3[2]) begin
        state_d = S_MUL;
        acc_d   = {{XLEN{1'b0}}, b_mag};
        opb_d   = a_mag;
        cnt_d   = CW'(XLEN);
      end else if (is_m && (i_in2 == '0)) begin
        state_d = S_DONE;
        out_d   = f3[1] ? i_in1 : '1;
      end else if (is_m && sgn1 && (i_in1 == SMIN) && (i_in2 == '1)) begin
        state_d = S_DONE;
        out_d   = f3[1] ? '0 : i_in1;
      end else if (is_m) begin
        state_d = S_DIV;
        acc_d   = {{XLEN{1'b0}}, a_mag};
        opb_d   = b_mag;
        cnt_d   = CW'(XLEN);
      end else if ((f3 == 3'd1) || (f3 == 3'd5)) begin
        if (shamt == '0) begin
          state_d = S_DONE;
          out_d   = i_in1;
        end else begin
          state_d = S_SHIFT;
          acc_d   = {{XLEN{1'b0}}, i_in1};
          cnt_d   = CW'(shamt);
        end
      end else begin
        state_d = S_DONE;
        out_d   = base_res;
      end
    end else begin
      case (state_q)
        S_SHIFT: begin
          acc_d[XLEN-1:0] = sh_res;
          cnt_d = cnt_q - amt;
          if (cnt_q <= CW'(SHIFT_STEP)) begin
            state_d = S_DONE;
            out_d   = sh_res;
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_DONE;
          out_d   = fix_res;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      sra_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      sra_q   <= sra_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      out_q   <= out_d;
    end
  end

  // Opcode, rd and rs fields are decoded upstream.
  logic unused_instr;
  assign unused_instr = ^i_instr;
endmodule
